// File: rtl/data_memory_sized.sv
// Byte-addressable big-endian data memory with byte/half/word access, sign/zero-extended loads,
// a post-reset clearing sweep, and a sticky fault flag for misaligned or out-of-range accesses.
module data_memory_sized #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned ADDR_W      = 32,
    parameter logic [31:0] INIT_VALUE  = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic              misaligned,
    output logic              out_of_range,
    output logic              fault
);
    localparam int unsigned N_BYTES = 4 * DEPTH_WORDS;
    localparam int unsigned WORD_AW = $clog2(DEPTH_WORDS);
    localparam int unsigned BYTE_AW = WORD_AW + 2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORD_AW-1:0]  r_idx;
    logic [31:0]         r_mem [DEPTH_WORDS];
    logic [31:0]         r_hold;
    logic                r_fault;

    logic                w_ready;
    logic                w_init_we;
    logic                w_rw;
    logic [1:0]          w_off;
    logic [WORD_AW-1:0]  w_widx;
    logic                w_mis_raw;
    logic                w_oor_raw;
    logic                w_legal;
    logic                w_store;
    logic                w_load_en;
    logic [3:0]          w_be;
    logic [31:0]         w_wlane;
    logic [31:0]         w_rword;
    logic [7:0]          w_rbyte;
    logic [15:0]         w_rhalf;
    logic [31:0]         w_load;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_INIT;
        else       r_state <= w_state_nxt;
    end

    // Next state: leave INIT once the last word has been written
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_INIT && r_idx == WORD_AW'(DEPTH_WORDS - 1))
            w_state_nxt = S_RUN;
    end

    // FSM outputs
    always_comb begin
        w_ready   = 1'b0;
        w_init_we = 1'b0;
        case (r_state)
            S_INIT:  w_init_we = 1'b1;
            S_RUN:   w_ready   = 1'b1;
            default: w_ready   = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)          r_idx <= '0;
        else if (w_init_we) r_idx <= r_idx + WORD_AW'(1);
    end

    // Request decode and legality
    assign w_rw      = mem_read | mem_write;
    assign w_off     = address[1:0];
    assign w_widx    = address[BYTE_AW-1:2];
    assign w_mis_raw = (size == SZ_HALF && address[0]) ||
                       (size == SZ_WORD && w_off != 2'b00) ||
                       (size == 2'b11);
    assign w_oor_raw = (address >= ADDR_W'(N_BYTES));
    assign w_legal   = w_ready & ~w_mis_raw & ~w_oor_raw;

    assign misaligned   = w_ready & w_rw & w_mis_raw;
    assign out_of_range = w_ready & w_rw & w_oor_raw;

    // Lane enables and replicated store data; lane 3 holds the lowest byte address
    always_comb begin
        w_be    = 4'b0000;
        w_wlane = write_data;
        case (size)
            SZ_BYTE: begin
                w_wlane = {4{write_data[7:0]}};
                w_be    = 4'b1000 >> w_off;
            end
            SZ_HALF: begin
                w_wlane = {2{write_data[15:0]}};
                w_be    = w_off[1] ? 4'b0011 : 4'b1100;
            end
            SZ_WORD: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_store = mem_write & w_legal & ~reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_init_we) begin
                r_mem[r_idx] <= INIT_VALUE;
            end else if (w_store) begin
                for (int i = 0; i < 4; i++)
                    if (w_be[i]) r_mem[w_widx][8*i +: 8] <= w_wlane[8*i +: 8];
            end
        end
    end

    // Combinational load path with lane select and extension
    assign w_rword = r_mem[w_widx];
    assign w_rhalf = w_off[1] ? w_rword[15:0] : w_rword[31:16];

    always_comb begin
        case (w_off)
            2'd0:    w_rbyte = w_rword[31:24];
            2'd1:    w_rbyte = w_rword[23:16];
            2'd2:    w_rbyte = w_rword[15:8];
            default: w_rbyte = w_rword[7:0];
        endcase
    end

    always_comb begin
        w_load = w_rword;
        case (size)
            SZ_BYTE: w_load = unsigned_ld ? {24'h0, w_rbyte} : {{24{w_rbyte[7]}}, w_rbyte};
            SZ_HALF: w_load = unsigned_ld ? {16'h0, w_rhalf} : {{16{w_rhalf[15]}}, w_rhalf};
            default: w_load = w_rword;
        endcase
    end

    assign w_load_en = mem_read & w_legal;

    // Hold register keeps read_data stable between loads; fault is sticky until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold  <= 32'h0;
            r_fault <= 1'b0;
        end else begin
            if (w_load_en)                  r_hold  <= w_load;
            if (misaligned | out_of_range)  r_fault <= 1'b1;
        end
    end

    assign read_data = w_load_en ? w_load : r_hold;
    assign ready     = w_ready;
    assign fault     = r_fault;

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized: stimulus queues expected values, a negedge monitor checks them.
module tb_data_memory_sized;
    localparam int unsigned DEPTH = 64;
    localparam int SIG_RD = 0, SIG_RDY = 1, SIG_MIS = 2, SIG_OOR = 3, SIG_FLT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] read_data;
    logic        ready;
    logic        misaligned;
    logic        out_of_range;
    logic        fault;

    always #5 clk = ~clk;

    data_memory_sized #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .INIT_VALUE(32'h0)) dut (
        .clk(clk), .reset(reset), .address(address), .write_data(write_data),
        .mem_write(mem_write), .mem_read(mem_read), .size(size), .unsigned_ld(unsigned_ld),
        .read_data(read_data), .ready(ready), .misaligned(misaligned),
        .out_of_range(out_of_range), .fault(fault)
    );

    string       q_name[$];
    int          q_sig[$];
    logic [31:0] q_exp[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Monitor: compare every expectation queued for this cycle
    always @(negedge clk) begin
        while (q_sig.size() > 0) begin
            string       nm;
            int          s;
            logic [31:0] e;
            logic [31:0] a;
            nm = q_name.pop_front();
            s  = q_sig.pop_front();
            e  = q_exp.pop_front();
            case (s)
                SIG_RD:  a = read_data;
                SIG_RDY: a = {31'h0, ready};
                SIG_MIS: a = {31'h0, misaligned};
                SIG_OOR: a = {31'h0, out_of_range};
                default: a = {31'h0, fault};
            endcase
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h", nm, a, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_sig(input string nm, input int sig, input logic [31:0] v);
        q_name.push_back(nm);
        q_sig.push_back(sig);
        q_exp.push_back(v);
    endtask

    task automatic idle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input logic uns);
        mem_read    = rd;
        mem_write   = wr;
        address     = a;
        write_data  = wd;
        size        = sz;
        unsigned_ld = uns;
    endtask

    task automatic do_reset();
        tick();
        idle();
        reset = 1'b1;
        tick();
        exp_sig("rst_ready", SIG_RDY, 32'h0);
        exp_sig("rst_fault", SIG_FLT, 32'h0);
        exp_sig("rst_rdata", SIG_RD, 32'h0);
        reset = 1'b0;
    endtask

    // Walk n cycles after reset release; ready must rise after exactly DEPTH cycles
    task automatic wait_init(input int n, input bit poke);
        for (int k = 1; k <= n; k++) begin
            tick();
            idle();
            if (poke && k == 10) begin
                drive(1'b1, 1'b1, 32'h0, 32'hDEADBEEF, 2'b10, 1'b0);
                exp_sig("init_mis", SIG_MIS, 32'h0);
                exp_sig("init_oor", SIG_OOR, 32'h0);
                exp_sig("init_rd", SIG_RD, 32'h0);
            end
            if (poke && k == 11) begin
                drive(1'b1, 1'b0, 32'h1, 32'h0, 2'b11, 1'b0);
                exp_sig("init_sz11_mis", SIG_MIS, 32'h0);
            end
            exp_sig($sformatf("init_ready_c%0d", k), SIG_RDY, (k >= int'(DEPTH)) ? 32'h1 : 32'h0);
        end
    endtask

    task automatic ld(input string nm, input logic [31:0] a, input logic [1:0] sz,
                      input logic uns, input logic [31:0] exp_v);
        tick();
        drive(1'b1, 1'b0, a, 32'h0, sz, uns);
        exp_sig(nm, SIG_RD, exp_v);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
        tick();
        drive(1'b0, 1'b1, a, wd, sz, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);

        do_reset();
        wait_init(DEPTH, 1'b1);
        ld("ld_fc_after_init", 32'h0FC, 2'b10, 1'b0, 32'h0);
        exp_sig("fault_after_init", SIG_FLT, 32'h0);
        exp_sig("mis_legal", SIG_MIS, 32'h0);
        exp_sig("oor_legal", SIG_OOR, 32'h0);
        ld("ld_0_init_store_ignored", 32'h0, 2'b10, 1'b0, 32'h0);

        // Big-endian lane selection and extension
        st(32'h0, 32'hFFFFFFFB, 2'b10);
        ld("lb_3_signed", 32'h3, 2'b00, 1'b0, 32'hFFFFFFFB);
        ld("lb_3_unsigned", 32'h3, 2'b00, 1'b1, 32'h000000FB);
        ld("lh_2_signed", 32'h2, 2'b01, 1'b0, 32'hFFFFFFFB);
        ld("lh_0_unsigned", 32'h0, 2'b01, 1'b1, 32'h0000FFFF);
        ld("lb_0_unsigned", 32'h0, 2'b00, 1'b1, 32'h000000FF);

        st(32'h4, 32'h00000002, 2'b10);
        st(32'h5, 32'hFFFFFF5A, 2'b00);
        ld("lw_4_after_sb5", 32'h4, 2'b10, 1'b0, 32'h005A0002);
        st(32'h6, 32'h1234BEEF, 2'b01);
        ld("lw_4_after_sh6", 32'h4, 2'b10, 1'b0, 32'h005ABEEF);
        ld("lb_5_signed", 32'h5, 2'b00, 1'b0, 32'h0000005A);
        ld("lw_4_hold", 32'h4, 2'b10, 1'b0, 32'h005ABEEF);
        exp_sig("fault_before_mis", SIG_FLT, 32'h0);

        // Misaligned and reserved-size accesses
        tick();
        drive(1'b0, 1'b1, 32'h6, 32'hFFFFFFFF, 2'b10, 1'b0);
        exp_sig("sw6_mis", SIG_MIS, 32'h1);
        exp_sig("sw6_oor", SIG_OOR, 32'h0);
        exp_sig("sw6_fault_same_cycle", SIG_FLT, 32'h0);
        exp_sig("sw6_rd_hold", SIG_RD, 32'h005ABEEF);
        ld("lh3_rd_hold", 32'h3, 2'b01, 1'b0, 32'h005ABEEF);
        exp_sig("lh3_mis", SIG_MIS, 32'h1);
        exp_sig("fault_after_mis", SIG_FLT, 32'h1);
        ld("sz11_rd_hold", 32'h8, 2'b11, 1'b0, 32'h005ABEEF);
        exp_sig("sz11_mis", SIG_MIS, 32'h1);
        ld("lw_4_unchanged", 32'h4, 2'b10, 1'b0, 32'h005ABEEF);
        exp_sig("fault_sticky", SIG_FLT, 32'h1);
        tick();
        idle();
        exp_sig("idle_mis", SIG_MIS, 32'h0);
        exp_sig("idle_oor", SIG_OOR, 32'h0);
        exp_sig("idle_rd_hold", SIG_RD, 32'h005ABEEF);

        // Reset during RUN clears fault and re-runs the sweep
        do_reset();
        wait_init(DEPTH, 1'b0);
        ld("lw_4_cleared", 32'h4, 2'b10, 1'b0, 32'h0);
        exp_sig("fault_cleared", SIG_FLT, 32'h0);

        // Top-of-array boundary and out-of-range
        st(32'h4, 32'h11223344, 2'b10);
        st(32'hFF, 32'h00000081, 2'b00);
        ld("lb_ff_signed", 32'hFF, 2'b00, 1'b0, 32'hFFFFFF81);
        exp_sig("lb_ff_oor", SIG_OOR, 32'h0);
        ld("lw_4_hold2", 32'h4, 2'b10, 1'b0, 32'h11223344);
        ld("lw_100_rd_hold", 32'h100, 2'b10, 1'b0, 32'h11223344);
        exp_sig("lw_100_oor", SIG_OOR, 32'h1);
        exp_sig("lw_100_mis", SIG_MIS, 32'h0);
        exp_sig("lw_100_fault_same_cycle", SIG_FLT, 32'h0);
        tick();
        idle();
        exp_sig("fault_after_oor", SIG_FLT, 32'h1);
        exp_sig("idle_oor2", SIG_OOR, 32'h0);
        st(32'h100, 32'hAAAAAAAA, 2'b10);
        ld("lw_0_no_wrap", 32'h0, 2'b10, 1'b0, 32'h0);
        ld("lw_hi_addr_rd_hold", 32'h80000004, 2'b10, 1'b0, 32'h0);
        exp_sig("lw_hi_addr_oor", SIG_OOR, 32'h1);
        ld("lw_fc_word", 32'hFC, 2'b10, 1'b0, 32'h00000081);

        // Same-cycle store and load show pre-write data
        tick();
        drive(1'b1, 1'b1, 32'h8, 32'h12345678, 2'b10, 1'b0);
        exp_sig("rw8_old", SIG_RD, 32'h0);
        ld("rw8_new", 32'h8, 2'b10, 1'b0, 32'h12345678);

        // Reset in the middle of INIT restarts the sweep
        do_reset();
        wait_init(30, 1'b0);
        do_reset();
        wait_init(DEPTH, 1'b0);
        ld("lw_8_cleared", 32'h8, 2'b10, 1'b0, 32'h0);
        exp_sig("fault_after_midinit", SIG_FLT, 32'h0);

        tick();
        idle();
        tick();
        tick();
        if (q_sig.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q_sig.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
- Parametrised successor to the single-cycle datapath's word-only data memory.
- Byte-addressable, big-endian store that supports byte, halfword and word loads and stores; loads are sign- or zero-extended.
- After reset, an internal sequencer clears the whole array before accepting accesses.
- Detects misaligned, illegal-size and out-of-range accesses, suppresses them, and records them in a sticky fault flag for the datapath and bench.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words; total bytes = 4*DEPTH_WORDS. Must be a power of two, at least 2.
- ADDR_W, 32, width of the address port.
- INIT_VALUE, 32'h0, value written into every word during the init sweep.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_W  byte address.
- write_data  in  32  store data; the low bits are used for byte/half stores.
- mem_write  in  1  store request.
- mem_read  in  1  load request.
- size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- unsigned_ld  in  1  1 = zero-extend a load, 0 = sign-extend.
- read_data  out  32  load result.
- ready  out  1  array initialised; accesses accepted.
- misaligned  out  1  combinational: the current request is misaligned or uses size=11.
- out_of_range  out  1  combinational: the current request exceeds the array.
- fault  out  1  sticky error flag.

Behaviour:
- Storage and byte order:
  - Storage is DEPTH_WORDS x 32 bits.
  - Big-endian: the byte at address A sits in bits [31:24] of word A>>2 when A[1:0]=0, and in bits [7:0] when A[1:0]=3.
- State machine: INIT, RUN.
  - On reset=1, the FSM enters INIT, the init index goes to 0, ready=0 and fault=0.
  - The hold register is cleared to 0, so read_data=0.
  - In INIT, each cycle writes INIT_VALUE to word[index] and increments the index.
  - When the write to index DEPTH_WORDS-1 completes, the FSM enters RUN and ready=1 on the following cycle. INIT therefore lasts exactly DEPTH_WORDS cycles after reset deasserts.
  - Asserting reset mid-INIT or mid-RUN restarts INIT from index 0.
  - In INIT, mem_write and mem_read are ignored: no store happens and the error flags are forced to 0.
- Request legality (RUN only):
  - misaligned = mem_rd_or_wr & ((size==01 & address[0]) | (size==10 & address[1:0]!=0) | size==11).
  - out_of_range = mem_rd_or_wr & (address >= 4*DEPTH_WORDS). An aligned access never straddles the end of the array.
  - legal = ready & !misaligned & !out_of_range.
- Store:
  - On the rising edge with mem_write & legal, only the addressed byte lanes are updated.
  - Byte stores write write_data[7:0]; half stores write write_data[15:0] to lanes A and A+1; word stores write all four lanes.
  - Other lanes are unchanged.
- Load (combinational, so the single-cycle datapath sees data in the same cycle):
  - When mem_read & legal, read_data = extended lane data using the current array contents.
  - The selected lanes are byte A or halfword A..A+1, extended by bit 7 or bit 15 respectively unless unsigned_ld=1.
  - Word loads return the word unchanged.
  - Otherwise read_data = hold register.
  - On each rising edge with mem_read & legal, the hold register captures the load result. read_data is therefore stable between loads, with no latch.
- Simultaneous read and write to the same address in one cycle: read_data shows the pre-write contents; the store lands at the edge.
- fault:
  - Set on the rising edge when ready & (misaligned | out_of_range).
  - Cleared only by reset.
  - An illegal access never modifies the array or the hold register.
- mem_read=mem_write=0: no flags are raised and nothing changes.

Test Plan:
- Reset with DEPTH_WORDS=64, reset high for 1 cycle then low -> ready=0 for exactly 64 cycles, then 1. A word load at 0x0FC then returns 0, and fault=0.
- Word store 32'hFFFFFFFB at 0x0, then byte loads at 0x3 -> signed 32'hFFFFFFFB, unsigned 32'h000000FB. A half load at 0x2 signed -> 32'hFFFFFFFB.
- Byte store 8'h5A at 0x5 over word 32'h00000002 at 0x4 -> word load at 0x4 returns 32'h005A0002.
- Word store at 0x6 or half load at 0x3 -> misaligned=1 that cycle, fault=1 from the next cycle, and memory unchanged. A load with size=11 behaves the same way.
- Word load at 0x100 -> out_of_range=1, read_data holds the previous value, and fault is set.
- Store 32'h12345678 at 0x8 with a same-cycle load at 0x8 -> read_data shows old 32'h00000000, then 32'h12345678 next cycle. Reset asserted mid-INIT at index 30 -> INIT restarts and ready rises 64 cycles after release.
